// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-N stream demultiplexer.
package demux_pkg;
  localparam int DW_DEF = 8;
  localparam int N_DEF  = 8;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  localparam int ERR_W = 8;
endpackage

// File: rtl/demux_stream_n_if.sv
// Producer/consumer bundle of the demultiplexer; the block itself takes the slave view.
interface demux_stream_n_if
  import demux_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int N  = N_DEF
);
  localparam int SELW = $clog2(N);

  logic                 mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_data;
  logic [SELW-1:0]      in_sel;
  logic [N-1:0]         out_valid;
  logic [N-1:0]         out_ready;
  logic [N*DW-1:0]      out_data;
  logic [SELW-1:0]      rr_ptr;
  logic [ERR_W-1:0]     err_cnt;

  modport slave (
    input  mode, in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, rr_ptr, err_cnt
  );

  modport master (
    output mode, in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, rr_ptr, err_cnt
  );
endinterface

// File: rtl/demux_stream_n_slot.sv
// One-entry holding register for a single output channel.
module demux_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          drain,
  input  logic [DW-1:0] din,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          free
);
  // Free also when the consumer takes the current beat this cycle.
  assign free = !valid || drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux_stream_n.sv
// Registered 1-to-N stream demux: addressed or round-robin routing into per-channel holding slots.
module demux_stream_n
  import demux_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int N  = N_DEF,
  localparam int SELW = $clog2(N)
) (
  input logic             clk,
  input logic             rst,
  demux_stream_n_if.slave bus
);
  logic [SELW-1:0]         tgt;
  logic [SELW-1:0]         rr_q;
  logic [ERR_W-1:0]        err_q;
  logic                    in_range;
  logic                    ready_c;
  logic                    accept;
  logic [N-1:0]            free_vec;
  logic [N-1:0]            load_vec;
  logic [(1<<SELW)-1:0]    free_pad;
  logic                    slot_valid [N];
  logic [DW-1:0]           slot_data  [N];

  always_comb begin
    tgt = (bus.mode == MODE_RR) ? rr_q : bus.in_sel;
  end

  // Only a non-power-of-two N leaves select codes with no channel behind them.
  generate
    if ((1 << SELW) == N) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_part
      assign in_range = (tgt <= SELW'(N - 1));
    end
  endgenerate

  always_comb begin
    free_pad = '0;
    free_pad[N-1:0] = free_vec;
  end

  assign ready_c      = !in_range || free_pad[tgt];
  assign bus.in_ready = ready_c;
  assign accept       = bus.in_valid && ready_c;

  always_comb begin
    load_vec = '0;
    for (int k = 0; k < N; k++) begin
      load_vec[k] = accept && in_range && (tgt == SELW'(k));
    end
  end

  generate
    for (genvar k = 0; k < N; k++) begin : g_slot
      demux_slot #(.DW(DW)) u_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (load_vec[k]),
        .drain (bus.out_ready[k]),
        .din   (bus.in_data),
        .valid (slot_valid[k]),
        .data  (slot_data[k]),
        .free  (free_vec[k])
      );
    end
  endgenerate

  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    for (int k = 0; k < N; k++) begin
      bus.out_valid[k]         = slot_valid[k];
      bus.out_data[k*DW +: DW] = slot_data[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q  <= '0;
      err_q <= '0;
    end else begin
      if (accept && bus.mode == MODE_RR) begin
        rr_q <= (rr_q == SELW'(N - 1)) ? '0 : rr_q + 1'b1;
      end
      if (accept && !in_range && err_q != '1) begin
        err_q <= err_q + 1'b1;
      end
    end
  end

  assign bus.rr_ptr  = rr_q;
  assign bus.err_cnt = err_q;
endmodule

// File: tb/tb_demux_stream_n.sv
// Bench for demux_stream_n: N=8 and N=6 instances driven in lockstep against a channel-array model.
module tb_demux_stream_n;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode_s = 1'b0;
  logic       vld = 1'b0;
  logic [7:0] dat = 8'h00;
  logic [2:0] sel = 3'd0;
  logic [7:0] ordy = 8'h00;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_stream_n_if #(.DW(8), .N(8)) if8 ();
  demux_stream_n_if #(.DW(8), .N(6)) if6 ();

  assign if8.mode = mode_s;  assign if6.mode = mode_s;
  assign if8.in_valid = vld; assign if6.in_valid = vld;
  assign if8.in_data = dat;  assign if6.in_data = dat;
  assign if8.in_sel = sel;   assign if6.in_sel = sel;
  assign if8.out_ready = ordy;
  assign if6.out_ready = ordy[5:0];

  demux_stream_n #(.DW(8), .N(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  demux_stream_n #(.DW(8), .N(6)) dut6 (.clk(clk), .rst(rst), .bus(if6));

  // Model: per-channel held beat, round-robin index, drop counter.
  int   nch [2] = '{8, 6};
  bit   mv [2][8];
  byte  md [2][8];
  int   mrr [2];
  int   merr [2];
  bit   nacc [2];
  int   nt [2];
  bit   last_rdy [2];

  task automatic cmp(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin mv[d][k] = 0; md[d][k] = 0; end
      mrr[d] = 0; merr[d] = 0;
    end
  endtask

  task automatic check_dut(int d);
    int n, t, arr, aerr;
    bit rdy, ardy;
    logic [7:0] av, ev;
    logic [63:0] ad;
    n = nch[d];
    if (d == 0) begin
      ardy = if8.in_ready; av = if8.out_valid; ad = if8.out_data;
      arr = int'(if8.rr_ptr); aerr = int'(if8.err_cnt);
    end else begin
      ardy = if6.in_ready; av = {2'b00, if6.out_valid}; ad = {16'h0, if6.out_data};
      arr = int'(if6.rr_ptr); aerr = int'(if6.err_cnt);
    end
    t = mode_s ? mrr[d] : int'(sel);
    rdy = (t >= n) || !mv[d][t] || ordy[t];
    ev = 8'h00;
    for (int k = 0; k < n; k++) ev[k] = mv[d][k];
    cmp($sformatf("in_ready dut%0d", d), int'(ardy), int'(rdy));
    cmp($sformatf("out_valid dut%0d", d), int'(av), int'(ev));
    for (int k = 0; k < n; k++)
      if (mv[d][k]) cmp($sformatf("out_data[%0d] dut%0d", k, d), int'(ad[k*8 +: 8]), int'(md[d][k]) & 8'hFF);
    cmp($sformatf("rr_ptr dut%0d", d), arr, mrr[d]);
    cmp($sformatf("err_cnt dut%0d", d), aerr, merr[d]);
    nacc[d] = vld && rdy;
    nt[d] = t;
    last_rdy[d] = ardy;
  endtask

  task automatic commit(int d);
    int n;
    n = nch[d];
    for (int k = 0; k < n; k++) if (mv[d][k] && ordy[k]) mv[d][k] = 0;
    if (nacc[d]) begin
      if (nt[d] < n) begin mv[d][nt[d]] = 1; md[d][nt[d]] = dat; end
      else if (merr[d] < 255) merr[d]++;
      if (mode_s) mrr[d] = (mrr[d] + 1) % n;
    end
  endtask

  // One clock: check at the falling edge, advance the model past the rising edge.
  task automatic cyc();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    commit(0);
    commit(1);
    #1;
  endtask

  task automatic do_reset();
    vld = 0; ordy = 8'h00;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         mode;
    logic [2:0] sel;
    logic [7:0] data;
    bit         valid;
    logic [7:0] ordy;
    bit         exp_rdy;
    logic [7:0] exp_ov;
    int         exp_rr;
    int         chk_ch;
    logic [7:0] chk_data;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{0, 3'd5, 8'hA5, 1, 8'h00, 1, 8'h20, 0, 5, 8'hA5};
    vt[1] = '{0, 3'd5, 8'h11, 1, 8'h00, 0, 8'h20, 0, 5, 8'hA5};
    vt[2] = '{0, 3'd2, 8'h22, 1, 8'h00, 1, 8'h24, 0, 2, 8'h22};
    vt[3] = '{1, 3'd0, 8'h33, 1, 8'h00, 1, 8'h25, 1, 0, 8'h33};
    vt[4] = '{0, 3'd5, 8'h00, 0, 8'h20, 1, 8'h05, 1, -1, 8'h00};
    vt[5] = '{1, 3'd0, 8'h44, 1, 8'h00, 1, 8'h07, 2, 1, 8'h44};
    vt[6] = '{0, 3'd1, 8'h3C, 1, 8'h02, 1, 8'h07, 2, 1, 8'h3C};
    vt[7] = '{0, 3'd0, 8'h00, 0, 8'hFF, 1, 8'h00, 2, -1, 8'h00};

    do_reset();
    cmp("post-reset in_ready", int'(if8.in_ready), 1);

    // Addressed routing, stall, drain and drain/fill collision.
    for (int i = 0; i < 8; i++) begin
      mode_s = vt[i].mode; sel = vt[i].sel; dat = vt[i].data;
      vld = vt[i].valid; ordy = vt[i].ordy;
      cyc();
      cmp($sformatf("tbl%0d in_ready", i), int'(last_rdy[0]), int'(vt[i].exp_rdy));
      cmp($sformatf("tbl%0d out_valid", i), int'(if8.out_valid), int'(vt[i].exp_ov));
      cmp($sformatf("tbl%0d rr_ptr", i), int'(if8.rr_ptr), vt[i].exp_rr);
      if (vt[i].chk_ch >= 0)
        cmp($sformatf("tbl%0d out_data", i), int'(if8.out_data[vt[i].chk_ch*8 +: 8]), int'(vt[i].chk_data));
    end

    // Back-to-back beats into channel 3.
    mode_s = 0; sel = 3'd3; ordy = 8'h08; vld = 1;
    for (int i = 0; i < 16; i++) begin
      dat = 8'(i);
      cyc();
      cmp($sformatf("b2b%0d in_ready", i), int'(last_rdy[0]), 1);
      cmp($sformatf("b2b%0d out_valid", i), int'(if8.out_valid), 8'h08);
      cmp($sformatf("b2b%0d out_data", i), int'(if8.out_data[24 +: 8]), i);
    end
    vld = 0;
    cyc();

    // Fill slots 2 and 5, then assert reset between edges.
    ordy = 8'h00; vld = 1;
    sel = 3'd2; dat = 8'h12; cyc();
    sel = 3'd5; dat = 8'h15; cyc();
    cmp("prefill out_valid", int'(if8.out_valid), 8'h24);
    vld = 0;
    #2 rst = 1'b1;
    #1;
    cmp("async rst out_valid", int'(if8.out_valid), 0);
    cmp("async rst rr_ptr", int'(if8.rr_ptr), 0);
    cmp("async rst err_cnt", int'(if6.err_cnt), 0);
    do_reset();

    // Round-robin wrap.
    mode_s = 1; ordy = 8'hFF; vld = 1;
    for (int i = 0; i < 10; i++) begin
      dat = 8'(8'h50 + i);
      cyc();
      cmp($sformatf("rr%0d out_valid", i), int'(if8.out_valid), 1 << (i % 8));
      cmp($sformatf("rr%0d out_data", i), int'(if8.out_data[(i % 8)*8 +: 8]), 8'h50 + i);
    end
    cmp("rr end rr_ptr", int'(if8.rr_ptr), 2);
    mode_s = 0; vld = 0;
    cyc();
    cmp("rr after mode0", int'(if8.rr_ptr), 2);

    // Out-of-range drop on N=6.
    mode_s = 0; sel = 3'd7; ordy = 8'h00; vld = 1;
    for (int i = 0; i < 300; i++) begin
      dat = 8'($urandom);
      cyc();
      if (i % 50 == 0 || i == 299) begin
        cmp($sformatf("oor%0d in_ready", i), int'(last_rdy[1]), 1);
        cmp($sformatf("oor%0d out_valid", i), int'(if6.out_valid), 0);
      end
      if (i == 253) cmp("oor err_cnt 254", int'(if6.err_cnt), 254);
    end
    cmp("oor err_cnt sat", int'(if6.err_cnt), 255);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      mode_s = 1'($urandom);
      sel = 3'($urandom_range(0, 7));
      vld = ($urandom_range(0, 3) != 0);
      dat = 8'($urandom);
      ordy = 8'($urandom);
      cyc();
    end

    rst = 1'b1;
    #1;
    cmp("final rst err_cnt", int'(if6.err_cnt), 0);
    cmp("final rst out_valid", int'(if6.out_valid), 0);
    do_reset();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/demux_stream_n.md
# demux_stream_n

Registered, parametrised 1-to-N stream demultiplexer. It generalises the team's combinational 1x2/1x4/1x8 demux cells into a clocked block with valid/ready handshake, a one-entry holding register per output channel, and two routing modes: addressed and auto round-robin. It sits between a single producer stream and N independent consumers, so one stalled consumer never corrupts or blocks traffic already held for the others.

## Interface
Parameters:
- DW, 8, data width in bits (≥1)
- N, 8, number of output channels (2..64; need not be a power of two)
- SELW, $clog2(N), select width (derived; do not override)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- mode  in  1  0 = addressed (in_sel), 1 = auto round-robin (internal pointer)
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- in_data  in  DW  input payload
- in_sel  in  SELW  target channel in addressed mode
- out_valid  out  N  per-channel holding register full
- out_ready  in  N  per-channel consumer ready
- out_data  out  N*DW  channel k occupies bits [k*DW +: DW]
- rr_ptr  out  SELW  current round-robin target
- err_cnt  out  8  count of dropped out-of-range beats, saturating

## Operation
- Target channel t: mode=1 gives rr_ptr; mode=0 gives in_sel.
- Slot k is free when !out_valid[k], or when out_valid[k] && out_ready[k] (drain and refill in the same cycle).
- in_ready = (t ≥ N) or slot t free.
- Accept = in_valid && in_ready.
  - With t < N: slot t loads in_data and sets out_valid[t].
  - With t ≥ N (addressed mode only, N not a power of two): the beat is consumed and discarded, and err_cnt increments, saturating at 255.
- A slot clears out_valid[k] on out_ready[k] && out_valid[k] unless it is refilled in the same cycle.
- rr_ptr advances by one only on an accepted beat in mode=1. It wraps N-1 → 0 and is never ≥ N.
- A mode change takes effect combinationally in the same cycle. rr_ptr holds its value across mode changes and does not move in mode=0.
- in_ready depends on in_sel and mode; it never depends on in_valid.
- out_data[k] holds its value while out_valid[k]=1 and !out_ready[k].
- Channels are fully independent: a stall on channel j does not affect acceptance for any t ≠ j.

## Timing
- Reset (asynchronous assert, synchronous-clean release): out_valid=0, out_data=0, rr_ptr=0, err_cnt=0. in_ready is then 1 for any in-range target.
- Latency: a beat accepted at edge n appears on out_valid/out_data right after edge n.
- Throughput: one beat per cycle sustained to any single channel whose out_ready is held high.
- Reset mid-operation: all held beats are lost and no out_valid glitches high. The first cycle after release behaves as the post-reset state.
- Simultaneous events on the same slot: drain + fill gives new data with out_valid staying 1. Fill with no drain while full cannot happen because in_ready=0.

## Structure
- Shared package demux_pkg: default DW/N constants, the mode encoding localparams (MODE_ADDR=0, MODE_RR=1), and the err_cnt width (8).
- One sub-module, demux_slot: a one-entry valid/data register with load, drain, and free outputs. It is instantiated N times in a generate loop.
- The top level holds the target mux, the ready mux, rr_ptr, and err_cnt.

## Test plan
- Reset check: assert rst mid-stream with slots 2 and 5 full → out_valid=0, rr_ptr=0, err_cnt=0 immediately, before any clock edge.
- Addressed routing: mode=0, in_sel=5, in_data=0xA5, out_ready=0 → out_valid=8'b0010_0000 and out_data[5]=0xA5 next cycle. A second beat to sel 5 sees in_ready=0. A beat to sel 2 is accepted.
- Back-to-back throughput: out_ready[3]=1, 16 beats 0x00..0x0F to sel 3 → in_ready stays 1, and all 16 beats appear in order with no gaps.
- Round-robin wrap: mode=1, N=8, all out_ready=1, 10 beats → channels 0..7 then 0, 1. rr_ptr=2 at the end. Switching to mode=0 leaves rr_ptr at 2.
- Out-of-range drop: N=6, mode=0, in_sel=7, 300 beats → in_ready=1 and no out_valid rises. err_cnt reads 255 and saturates there.
- Drain/fill collision: slot 1 full, out_ready[1]=1, new beat 0x3C to sel 1 in the same cycle → accepted, out_valid[1] stays 1, out_data[1]=0x3C.
